// File: rtl/regfile_scoreboard.sv
// Parametrised register file with byte-enabled writes, optional write-to-read
// forwarding and a per-register pending scoreboard used for hazard detection.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;

  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (wbe[b]) regs[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Set is applied after clear so a new producer overrides a retiring one.
  always_comb begin
    pend_nxt = pend;
    if (we) pend_nxt[waddr] = 1'b0;
    if (set_pend) pend_nxt[set_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend[i]);
  end

  // pend_cnt counts the registered bits, so it trails pend by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              bz [2];

  assign ra[0]  = raddr1;
  assign ra[1]  = raddr2;
  assign rdata1 = rd[0];
  assign rdata2 = rd[1];
  assign busy1  = bz[0];
  assign busy2  = bz[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic is_zero;
    logic fwd;

    assign is_zero = (ZERO_REG != 0) && (ra[p] == '0);
    assign fwd     = (BYPASS != 0) && we && (waddr == ra[p]) && !is_zero;

    always_comb begin
      rd[p] = regs[ra[p]];
      if (fwd) begin
        for (int b = 0; b < NB; b++)
          if (wbe[b]) rd[p][8*b +: 8] = wdata[8*b +: 8];
      end
      if (is_zero) rd[p] = '0;
      bz[p] = pend[ra[p]] && !fwd && !is_zero;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised bench for regfile_scoreboard: two instances (forwarding on/off)
// checked each cycle against an array-based model, plus directed literal checks.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        set_pend = 1'b0;
  logic [4:0]  set_addr = '0;

  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .set_pend(set_pend), .set_addr(set_addr), .busy1(busy1_b), .busy2(busy2_b),
    .pend_cnt(cnt_b));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .set_pend(set_pend), .set_addr(set_addr), .busy1(busy1_n), .busy2(busy2_n),
    .pend_cnt(cnt_n));

  // Reference model: architectural register contents, pending set, and count.
  logic [31:0] m_reg [32];
  logic [31:0] m_pend;
  int          m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_pend = '0;
      m_cnt  = 0;
    end else begin
      int c;
      c = $countones(m_pend);
      if (we && waddr != 0)
        for (int b = 0; b < 4; b++)
          if (wbe[b]) m_reg[waddr][8*b +: 8] = wdata[8*b +: 8];
      if (we) m_pend[waddr] = 1'b0;
      if (set_pend) m_pend[set_addr] = 1'b1;
      m_pend[0] = 1'b0;
      m_cnt = c;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bp);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_reg[a];
    if (bp && we && waddr == a)
      for (int b = 0; b < 4; b++)
        if (wbe[b]) v[8*b +: 8] = wdata[8*b +: 8];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit bp);
    if (a == 0) return 1'b0;
    if (bp && we && waddr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("rdata1_byp", 64'(rdata1_b), 64'(exp_rd(raddr1, 1)));
      check("rdata2_byp", 64'(rdata2_b), 64'(exp_rd(raddr2, 1)));
      check("rdata1_nob", 64'(rdata1_n), 64'(exp_rd(raddr1, 0)));
      check("rdata2_nob", 64'(rdata2_n), 64'(exp_rd(raddr2, 0)));
      check("busy1_byp", 64'(busy1_b), 64'(exp_busy(raddr1, 1)));
      check("busy2_byp", 64'(busy2_b), 64'(exp_busy(raddr2, 1)));
      check("busy1_nob", 64'(busy1_n), 64'(exp_busy(raddr1, 0)));
      check("busy2_nob", 64'(busy2_n), 64'(exp_busy(raddr2, 0)));
      check("cnt_byp", 64'(cnt_b), 64'(m_cnt));
      check("cnt_nob", 64'(cnt_n), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; set_pend = 1'b0; wbe = '0;
  endtask

  initial begin
    #12 rst = 1'b1;
    step();
    cmp_en = 1'b1;
    check("reset_cnt", 64'(cnt_b), 64'd0);
    check("reset_rd", 64'(rdata1_b), 64'd0);

    // Async reset discards register contents immediately
    we = 1; waddr = 3; wdata = 32'hDEADBEEF; wbe = 4'hF;
    step(); idle(); raddr1 = 3; #1;
    check("t1_written", 64'(rdata1_b), 64'hDEADBEEF);
    #1 rst = 1'b0; #1;
    check("t1_rst_rd", 64'(rdata1_b), 64'd0);
    check("t1_rst_rd_nb", 64'(rdata1_n), 64'd0);
    check("t1_rst_cnt", 64'(cnt_b), 64'd0);
    #1 rst = 1'b1;
    step();

    // Zero register
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    set_pend = 1; set_addr = 0; raddr1 = 0; #1;
    check("t2_rd0", 64'(rdata1_b), 64'd0);
    check("t2_busy0", 64'(busy1_n), 64'd0);
    step(); idle(); step();
    check("t2_cnt", 64'(cnt_b), 64'd0);
    check("t2_rd0_after", 64'(rdata1_n), 64'd0);

    // Byte enables with and without forwarding
    we = 1; waddr = 5; wdata = 32'h11223344; wbe = 4'hF;
    step();
    wdata = 32'hAABBCCDD; wbe = 4'b0101; raddr2 = 5; #1;
    check("t3_byp", 64'(rdata2_b), 64'h11BB33DD);
    check("t3_nobyp", 64'(rdata2_n), 64'h11223344);
    step(); idle(); #1;
    check("t3_post_b", 64'(rdata2_b), 64'h11BB33DD);
    check("t3_post_n", 64'(rdata2_n), 64'h11BB33DD);

    // Scoreboard set/clear timing
    set_pend = 1; set_addr = 7; step();
    set_addr = 9; step();
    set_pend = 0; raddr1 = 7; #1;
    check("t4_cnt1", 64'(cnt_b), 64'd1);
    step();
    check("t4_cnt2", 64'(cnt_b), 64'd2);
    check("t4_busy", 64'(busy1_b), 64'd1);
    we = 1; waddr = 7; wdata = 32'h77; wbe = 4'hF; #1;
    check("t4_busy_fwd", 64'(busy1_b), 64'd0);
    check("t4_busy_nofwd", 64'(busy1_n), 64'd1);
    step(); idle(); #1;
    check("t4_busy_nb_after", 64'(busy1_n), 64'd0);
    step();
    check("t4_cnt_after", 64'(cnt_b), 64'd1);

    // Set and retire on the same register in one cycle
    set_pend = 1; set_addr = 4; step();
    set_pend = 0; step();
    set_pend = 1; set_addr = 4; we = 1; waddr = 4; wdata = 32'hCAFEF00D; wbe = 4'hF;
    step(); idle(); raddr1 = 4; #1;
    check("t5_busy", 64'(busy1_b), 64'd1);
    check("t5_data", 64'(rdata1_b), 64'hCAFEF00D);
    step();
    check("t5_cnt", 64'(cnt_b), 64'd2);

    // Full occupancy
    for (int a = 1; a < 32; a++) begin
      set_pend = 1; set_addr = 5'(a); step();
    end
    idle(); step();
    check("t6_full", 64'(cnt_b), 64'd31);
    for (int a = 1; a < 32; a++) begin
      we = 1; waddr = 5'(a); wdata = $urandom; wbe = 4'(a); step();
    end
    idle(); step();
    check("t6_empty", 64'(cnt_b), 64'd0);

    // Random traffic, biased toward a few addresses to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 3) != 0);
      we       = ($urandom_range(0, 1) == 1);
      waddr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata    = $urandom;
      wbe      = 4'($urandom);
      raddr1   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      raddr2   = ($urandom_range(0, 4) == 0) ? raddr1 : 5'($urandom_range(0, 7));
      set_pend = ($urandom_range(0, 2) == 0);
      set_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0; #1 rst = 1'b1;
      end
      step();
    end
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
